// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared sizes and types for the synchronous FIFO
package fifo_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 16;
  localparam int PTR_WIDTH  = $clog2(DEPTH);
  localparam int CNT_WIDTH  = PTR_WIDTH + 1;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [PTR_WIDTH-1:0]  ptr_t;
  typedef logic [CNT_WIDTH-1:0]  cnt_t;

  // Occupancy value that means "every entry holds a word"
  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

endpackage

// File: rtl/fifo_if.sv
// rtl/fifo_if.sv - bundled push/pop handshake and status signals of the FIFO
interface fifo_if;
  import fifo_pkg::*;

  logic  push;
  data_t data_in;
  logic  pop;
  data_t data_out;
  logic  full;
  logic  empty;
  cnt_t  count;
  logic  overflow;
  logic  underflow;

  modport fifo (
    input  push, data_in, pop,
    output data_out, full, empty, count, overflow, underflow
  );

  modport tb (
    output push, data_in, pop,
    input  data_out, full, empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_WIDTH register array, synchronous write and registered read
module fifo_mem
  import fifo_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  wr_en,
  input  ptr_t  wr_addr,
  input  data_t wr_data,
  input  logic  rd_en,
  input  ptr_t  rd_addr,
  output data_t rd_data
);

  data_t mem [DEPTH];

  // Storage write; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register; holds its value between accepted pops, so a same-address
  // write in the same cycle (full, push+pop) returns the old entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo_top.sv
// rtl/sync_fifo_top.sv - single-clock FIFO: pointers, occupancy and status flags
module sync_fifo_top
  import fifo_pkg::*;
(
  input  logic wr_clk,
  input  logic wr_rst,
  fifo_if.fifo itf
);

  ptr_t wr_ptr;
  ptr_t rd_ptr;
  cnt_t count;
  logic overflow;
  logic underflow;
  logic full;
  logic empty;
  logic pop_ok;
  logic push_ok;

  // Flags come from the registered count only, never from the requests
  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // accepted when it is paired with an accepted pop
  assign pop_ok  = itf.pop && !empty;
  assign push_ok = itf.push && (!full || pop_ok);

  // Pointer advance on accepted transfers; wraps modulo DEPTH naturally
  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + ptr_t'(1);
    end
  end

  // Occupancy tracking; a simultaneous push and pop leaves it unchanged
  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      count <= '0;
    end else if (push_ok && !pop_ok) begin
      count <= count + cnt_t'(1);
    end else if (pop_ok && !push_ok) begin
      count <= count - cnt_t'(1);
    end
  end

  // One-cycle pulses for requests that were refused at this edge
  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= itf.push && !push_ok;
      underflow <= itf.pop && !pop_ok;
    end
  end

  fifo_mem u_mem (
    .clk     (wr_clk),
    .rst_n   (wr_rst),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr),
    .wr_data (itf.data_in),
    .rd_en   (pop_ok),
    .rd_addr (rd_ptr),
    .rd_data (itf.data_out)
  );

  assign itf.full      = full;
  assign itf.empty     = empty;
  assign itf.count     = count;
  assign itf.overflow  = overflow;
  assign itf.underflow = underflow;

endmodule

// File: tb/tb_sync_fifo_top.sv
// tb/tb_sync_fifo_top.sv - self-checking bench for sync_fifo_top against a queue model
module tb_sync_fifo_top;
  import fifo_pkg::*;

  logic clk;
  logic rst_n;

  fifo_if itf ();

  sync_fifo_top dut (
    .wr_clk (clk),
    .wr_rst (rst_n),
    .itf    (itf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed;
  int total;

  // Reference model: an ordered queue of words plus the last popped value
  logic [7:0] mq[$];
  logic [7:0] m_dout;
  bit         m_ovf;
  bit         m_unf;

  typedef struct {
    bit         push;
    bit         pop;
    logic [7:0] din;
    int         exp_count;
    bit         exp_full;
    bit         exp_empty;
    bit         exp_ovf;
    bit         exp_unf;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout = 8'h00;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic model_step(input bit p, input bit q, input logic [7:0] d);
    bit pop_ok;
    bit push_ok;
    pop_ok  = q && (mq.size() != 0);
    push_ok = p && ((mq.size() < DEPTH) || pop_ok);
    if (pop_ok)  m_dout = mq.pop_front();
    if (push_ok) mq.push_back(d);
    m_ovf = p && !push_ok;
    m_unf = q && !pop_ok;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".data_out"},  32'(itf.data_out),  32'(m_dout));
    check({tag, ".count"},     32'(itf.count),     32'(mq.size()));
    check({tag, ".full"},      32'(itf.full),      32'(mq.size() == DEPTH));
    check({tag, ".empty"},     32'(itf.empty),     32'(mq.size() == 0));
    check({tag, ".overflow"},  32'(itf.overflow),  32'(m_ovf));
    check({tag, ".underflow"}, 32'(itf.underflow), 32'(m_unf));
  endtask

  // One clock: drive requests, let the edge happen, sample 1 time unit later
  task automatic step(input string tag, input bit p, input bit q, input logic [7:0] d);
    itf.push    = p;
    itf.pop     = q;
    itf.data_in = d;
    @(posedge clk);
    #1;
    model_step(p, q, d);
    check_model(tag);
    itf.push = 1'b0;
    itf.pop  = 1'b0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    itf.push    = 1'b0;
    itf.pop     = 1'b0;
    itf.data_in = 8'h00;
    model_reset();

    // Reset held for two cycles
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.empty",     32'(itf.empty),     32'd1);
    check("reset.full",      32'(itf.full),      32'd0);
    check("reset.count",     32'(itf.count),     32'd0);
    check("reset.data_out",  32'(itf.data_out),  32'd0);
    check("reset.overflow",  32'(itf.overflow),  32'd0);
    check("reset.underflow", 32'(itf.underflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: push, pop, din, count, full, empty, ovf, unf, dout
    vecs[0]  = '{1, 0, 8'hA5, 1, 0, 0, 0, 0, 8'h00};
    vecs[1]  = '{1, 0, 8'h3C, 2, 0, 0, 0, 0, 8'h00};
    vecs[2]  = '{0, 1, 8'h00, 1, 0, 0, 0, 0, 8'hA5};
    vecs[3]  = '{1, 1, 8'h77, 1, 0, 0, 0, 0, 8'h3C};
    vecs[4]  = '{0, 1, 8'h00, 0, 0, 1, 0, 0, 8'h77};
    vecs[5]  = '{0, 1, 8'h00, 0, 0, 1, 0, 1, 8'h77};
    vecs[6]  = '{1, 1, 8'h11, 1, 0, 0, 0, 1, 8'h77};
    vecs[7]  = '{0, 1, 8'h00, 0, 0, 1, 0, 0, 8'h11};
    vecs[8]  = '{0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h11};
    vecs[9]  = '{1, 0, 8'h22, 1, 0, 0, 0, 0, 8'h11};
    vecs[10] = '{0, 1, 8'h00, 0, 0, 1, 0, 0, 8'h22};
    for (int i = 0; i < 11; i++) begin
      step($sformatf("vec%0d", i), vecs[i].push, vecs[i].pop, vecs[i].din);
      check($sformatf("vec%0d.t_count", i), 32'(itf.count),     32'(vecs[i].exp_count));
      check($sformatf("vec%0d.t_full", i),  32'(itf.full),      32'(vecs[i].exp_full));
      check($sformatf("vec%0d.t_empty", i), 32'(itf.empty),     32'(vecs[i].exp_empty));
      check($sformatf("vec%0d.t_ovf", i),   32'(itf.overflow),  32'(vecs[i].exp_ovf));
      check($sformatf("vec%0d.t_unf", i),   32'(itf.underflow), 32'(vecs[i].exp_unf));
      check($sformatf("vec%0d.t_dout", i),  32'(itf.data_out),  32'(vecs[i].exp_dout));
    end

    // Overfill: 20 pushes of 0x00..0x13
    for (int i = 1; i <= 20; i++) begin
      step($sformatf("fill%0d", i), 1'b1, 1'b0, 8'(i - 1));
      check($sformatf("fill%0d.x_count", i), 32'(itf.count),    32'((i > 16) ? 16 : i));
      check($sformatf("fill%0d.x_ovf", i),   32'(itf.overflow), 32'(i > 16));
      check($sformatf("fill%0d.x_full", i),  32'(itf.full),     32'(i >= 16));
    end

    // Overdrain: 20 pops
    for (int i = 1; i <= 20; i++) begin
      step($sformatf("drain%0d", i), 1'b0, 1'b1, 8'h00);
      check($sformatf("drain%0d.x_dout", i),  32'(itf.data_out),  32'((i > 16) ? 15 : i - 1));
      check($sformatf("drain%0d.x_unf", i),   32'(itf.underflow), 32'(i > 16));
      check($sformatf("drain%0d.x_empty", i), 32'(itf.empty),     32'(i >= 16));
    end

    // Wrap-around: three rounds of push 10 / pop 10
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) step("wrap.push", 1'b1, 1'b0, 8'(8'h80 + r * 10 + i));
      for (int i = 0; i < 10; i++) begin
        step("wrap.pop", 1'b0, 1'b1, 8'h00);
        check("wrap.x_dout", 32'(itf.data_out), 32'(8'h80 + r * 10 + i));
      end
      check("wrap.x_count", 32'(itf.count), 32'd0);
    end

    // Full with simultaneous push/pop
    for (int i = 0; i < 16; i++) step("sim.fill", 1'b1, 1'b0, 8'(8'h40 + i));
    step("sim.full_both", 1'b1, 1'b1, 8'hAA);
    check("sim.full_both.x_count", 32'(itf.count),    32'd16);
    check("sim.full_both.x_ovf",   32'(itf.overflow), 32'd0);
    check("sim.full_both.x_dout",  32'(itf.data_out), 32'h40);
    for (int i = 0; i < 16; i++) step("sim.drain", 1'b0, 1'b1, 8'h00);
    check("sim.last_is_aa", 32'(itf.data_out), 32'hAA);

    // Empty with simultaneous push/pop
    step("sim.empty_both", 1'b1, 1'b1, 8'h55);
    check("sim.empty_both.x_unf",   32'(itf.underflow), 32'd1);
    check("sim.empty_both.x_count", 32'(itf.count),     32'd1);
    step("sim.empty_drain", 1'b0, 1'b1, 8'h00);
    check("sim.empty_drain.x_dout", 32'(itf.data_out), 32'h55);

    // Mid-operation asynchronous reset
    for (int i = 0; i < 5; i++) step("mid.push", 1'b1, 1'b0, 8'(8'hC0 + i));
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid.x_empty", 32'(itf.empty),    32'd1);
    check("mid.x_count", 32'(itf.count),    32'd0);
    check("mid.x_dout",  32'(itf.data_out), 32'd0);
    #3;
    rst_n = 1'b1;
    step("mid.pop", 1'b0, 1'b1, 8'h00);
    check("mid.pop.x_unf", 32'(itf.underflow), 32'd1);

    // Randomized traffic in phases biased toward filling, draining, and mixed
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 150; i++) begin
        int pp;
        int pq;
        pp = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
        pq = (ph == 0) ? 25 : (ph == 1) ? 75 : 50;
        step($sformatf("rnd%0d_%0d", ph, i),
             ($urandom_range(0, 99) < pp), ($urandom_range(0, 99) < pq), 8'($urandom));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
